// File: rtl/axis_stream_checker.sv
// AXI-Stream sink that checks an incrementing data pattern, tkeep legality,
// tid/tdest stability and packet length, while applying rotating backpressure.
module axis_stream_checker #(
  parameter int DATA_W      = 32,
  parameter int MAX_PKT_LEN = 256,
  parameter int CNT_W       = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tlast,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic [DATA_W/8-1:0] s_tstrb,
  input  logic                s_tuser,
  input  logic [7:0]          s_tid,
  input  logic [7:0]          s_tdest,
  input  logic                enable,
  input  logic [7:0]          ready_mask,
  output logic [31:0]         beat_count,
  output logic [CNT_W-1:0]    pkt_count,
  output logic [CNT_W-1:0]    err_count,
  output logic                err_sticky,
  output logic [DATA_W-1:0]   last_bad_data
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int LEN_W  = 9;
  localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_PKT_LEN + 1);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t             state_reg, state_next;
  logic               s_tready_reg;
  logic [2:0]         rot_idx_reg;
  logic [31:0]        beat_count_reg;
  logic [CNT_W-1:0]   pkt_count_reg, err_count_reg;
  logic               err_sticky_reg;
  logic [DATA_W-1:0]  last_bad_data_reg, expected_reg;
  logic [LEN_W-1:0]   pkt_beats_reg, pkt_beats_next;
  logic [7:0]         tid_reg, tdest_reg;

  logic               accept, first_beat, len_sat;
  logic               data_err, keep_err, stab_err, len_err, err_any;
  logic [KEEP_W-1:0]  keep_inc;
  logic               unused_inputs;

  assign unused_inputs = ^{s_tstrb, s_tuser};

  assign accept     = s_tvalid && s_tready_reg && (state_reg != IDLE);
  assign first_beat = (pkt_beats_reg == '0);
  assign len_sat    = (pkt_beats_reg == LEN_LIMIT);
  assign keep_inc   = s_tkeep + KEEP_W'(1);

  always_comb begin
    state_next     = state_reg;
    pkt_beats_next = len_sat ? pkt_beats_reg : pkt_beats_reg + LEN_W'(1);
    data_err       = 1'b0;
    keep_err       = 1'b0;
    stab_err       = 1'b0;
    len_err        = 1'b0;

    if (accept) begin
      data_err = (state_reg == RUN) && (s_tdata != expected_reg);
      // A last beat may be partial, but only as a run of ones starting at byte 0.
      if (s_tlast)
        keep_err = (s_tkeep == '0) || ((s_tkeep & keep_inc) != '0);
      else
        keep_err = !(&s_tkeep);
      stab_err = !first_beat && ((s_tid != tid_reg) || (s_tdest != tdest_reg));
      len_err  = !len_sat && (pkt_beats_next == LEN_LIMIT);
    end
    err_any = data_err || keep_err || stab_err || len_err;

    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = SYNC;
        SYNC:    if (accept) state_next = RUN;
        RUN:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg         <= IDLE;
      s_tready_reg      <= 1'b0;
      rot_idx_reg       <= '0;
      beat_count_reg    <= '0;
      pkt_count_reg     <= '0;
      err_count_reg     <= '0;
      err_sticky_reg    <= 1'b0;
      last_bad_data_reg <= '0;
      expected_reg      <= '0;
      pkt_beats_reg     <= '0;
      tid_reg           <= '0;
      tdest_reg         <= '0;
    end else begin
      state_reg    <= state_next;
      s_tready_reg <= enable && (state_reg != IDLE) && ready_mask[rot_idx_reg];
      if (state_reg != IDLE)
        rot_idx_reg <= rot_idx_reg + 3'd1;

      if (accept) begin
        beat_count_reg <= beat_count_reg + 32'd1;
        expected_reg   <= s_tdata + DATA_W'(1);
        pkt_beats_reg  <= s_tlast ? '0 : pkt_beats_next;
        if (first_beat) begin
          tid_reg   <= s_tid;
          tdest_reg <= s_tdest;
        end
        if (s_tlast && (pkt_count_reg != '1))
          pkt_count_reg <= pkt_count_reg + CNT_W'(1);
        if (err_any) begin
          err_sticky_reg <= 1'b1;
          if (err_count_reg != '1)
            err_count_reg <= err_count_reg + CNT_W'(1);
        end
        if (data_err)
          last_bad_data_reg <= s_tdata;
      end

      // Leaving the enabled states abandons any partial packet.
      if (!enable)
        pkt_beats_reg <= '0;
    end
  end

  assign s_tready      = s_tready_reg;
  assign beat_count    = beat_count_reg;
  assign pkt_count     = pkt_count_reg;
  assign err_count     = err_count_reg;
  assign err_sticky    = err_sticky_reg;
  assign last_bad_data = last_bad_data_reg;

endmodule

// File: tb/tb_axis_stream_checker.sv
// Directed bench for axis_stream_checker: pattern, keep, stability, length,
// backpressure rotation and asynchronous reset behaviour.
module tb_axis_stream_checker;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [3:0]  s_tkeep = 4'hF;
  logic [3:0]  s_tstrb = 4'hF;
  logic        s_tuser = 1'b0;
  logic [7:0]  s_tid = '0;
  logic [7:0]  s_tdest = '0;
  logic        enable = 1'b0;
  logic [7:0]  ready_mask = 8'hFF;
  logic [31:0] beat_count;
  logic [15:0] pkt_count, err_count;
  logic        err_sticky;
  logic [31:0] last_bad_data;

  int total = 0;
  int bad = 0;

  axis_stream_checker #(.DATA_W(32), .MAX_PKT_LEN(8), .CNT_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tkeep(s_tkeep), .s_tstrb(s_tstrb),
    .s_tuser(s_tuser), .s_tid(s_tid), .s_tdest(s_tdest),
    .enable(enable), .ready_mask(ready_mask),
    .beat_count(beat_count), .pkt_count(pkt_count), .err_count(err_count),
    .err_sticky(err_sticky), .last_bad_data(last_bad_data)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge.
  task automatic beat(input logic [31:0] d, input logic last, input logic [3:0] keep,
                      input logic [7:0] id);
    bit done = 1'b0;
    s_tdata = d; s_tlast = last; s_tkeep = keep; s_tid = id; s_tvalid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (s_tready) begin
        @(posedge aclk);
        done = 1'b1;
      end
      @(negedge aclk);
    end
    s_tvalid = 1'b0;
    if (!done) begin
      total++; bad++;
      $error("FAIL beat_timeout data=%0h observed=no_ready expected=ready", d);
    end
    $display("beat data=%08h last=%0b keep=%h id=%0d beats=%0d pkts=%0d errs=%0d",
             d, last, keep, id, beat_count, pkt_count, err_count);
  endtask

  task automatic resync();
    enable = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    enable = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    bit          prev_ready;
    int          acc;

    repeat (3) @(negedge aclk);
    check("reset_tready", {31'd0, s_tready}, 32'd0);
    check("reset_beats", beat_count, 32'd0);
    check("reset_pkts", {16'd0, pkt_count}, 32'd0);
    check("reset_errs", {16'd0, err_count}, 32'd0);
    aresetn = 1'b1;
    enable  = 1'b1;

    // Clean four-beat packet.
    beat(32'h42, 0, 4'hF, 0); beat(32'h43, 0, 4'hF, 0);
    beat(32'h44, 0, 4'hF, 0); beat(32'h45, 1, 4'hF, 0);
    check("basic_beats", beat_count, 32'd4);
    check("basic_pkts", {16'd0, pkt_count}, 32'd1);
    check("basic_errs", {16'd0, err_count}, 32'd0);

    // One bad datum, then resync to it.
    resync();
    beat(32'h42, 0, 4'hF, 0); beat(32'h43, 0, 4'hF, 0);
    beat(32'hDEADBEEF, 0, 4'hF, 0); beat(32'hDEADBEF0, 1, 4'hF, 0);
    check("data_errs", {16'd0, err_count}, 32'd1);
    check("data_last_bad", last_bad_data, 32'hDEADBEEF);
    check("data_sticky", {31'd0, err_sticky}, 32'd1);
    check("data_beats", beat_count, 32'd8);
    check("data_pkts", {16'd0, pkt_count}, 32'd2);

    // Expected value wraps through all-ones.
    resync();
    beat(32'hFFFFFFFE, 0, 4'hF, 0); beat(32'hFFFFFFFF, 0, 4'hF, 0);
    beat(32'h0, 1, 4'hF, 0);
    check("wrap_errs", {16'd0, err_count}, 32'd1);
    check("wrap_pkts", {16'd0, pkt_count}, 32'd3);

    beat(32'h1, 0, 4'h7, 0);
    check("keep_nonlast_errs", {16'd0, err_count}, 32'd2);
    beat(32'h2, 1, 4'h5, 0);
    check("keep_last_gap_errs", {16'd0, err_count}, 32'd3);
    beat(32'h3, 1, 4'h3, 0);
    check("keep_last_ok_errs", {16'd0, err_count}, 32'd3);
    check("keep_pkts", {16'd0, pkt_count}, 32'd5);

    beat(32'h4, 0, 4'hF, 0); beat(32'h5, 1, 4'hF, 1);
    check("stab_errs", {16'd0, err_count}, 32'd4);

    // Data and keep errors on the same beat count once.
    beat(32'h99, 0, 4'h1, 0);
    check("multi_errs", {16'd0, err_count}, 32'd5);
    check("multi_last_bad", last_bad_data, 32'h99);
    beat(32'h9A, 1, 4'hF, 0);
    check("multi_beats", beat_count, 32'd18);

    // Nine beats with MAX_PKT_LEN=8: one length error, then saturation.
    for (int i = 0; i < 9; i++) beat(32'h9B + i, 0, 4'hF, 0);
    check("len_over_errs", {16'd0, err_count}, 32'd6);
    beat(32'hA4, 1, 4'hF, 0);
    check("len_sat_errs", {16'd0, err_count}, 32'd6);
    for (int i = 0; i < 8; i++) beat(32'hA5 + i, (i == 7), 4'hF, 0);
    check("len_max_errs", {16'd0, err_count}, 32'd6);
    check("len_pkts", {16'd0, pkt_count}, 32'd9);
    check("len_beats", beat_count, 32'd36);

    // Enable drop abandons the partial packet; re-entry is a fresh sync.
    beat(32'hAD, 0, 4'hF, 0);
    resync();
    beat(32'h50, 1, 4'hF, 5);
    check("drop_errs", {16'd0, err_count}, 32'd6);
    check("drop_pkts", {16'd0, pkt_count}, 32'd10);
    beat(32'h51, 0, 4'hF, 5);
    enable = 1'b0;
    @(negedge aclk); @(negedge aclk);
    check("drop_mid_pkts", {16'd0, pkt_count}, 32'd10);
    check("drop_tready", {31'd0, s_tready}, 32'd0);
    enable = 1'b1;
    repeat (3) @(negedge aclk);
    check("reenable_tready", {31'd0, s_tready}, 32'd1);

    // Asynchronous reset between clock edges.
    #2 aresetn = 1'b0;
    #1;
    check("areset_tready", {31'd0, s_tready}, 32'd0);
    check("areset_beats", beat_count, 32'd0);
    check("areset_pkts", {16'd0, pkt_count}, 32'd0);
    check("areset_errs", {16'd0, err_count}, 32'd0);
    check("areset_sticky", {31'd0, err_sticky}, 32'd0);
    check("areset_last_bad", last_bad_data, 32'd0);
    $display("areset pulse at t=%0t", $time);

    // Rotating backpressure 0x55 with tvalid held high.
    ready_mask = 8'h55;
    @(negedge aclk);
    d = 32'h10;
    s_tdata = d; s_tlast = 1'b0; s_tkeep = 4'hF; s_tid = '0; s_tvalid = 1'b1;
    aresetn = 1'b1;
    prev_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge aclk);
      if (prev_ready) begin
        d = d + 32'd1;
        s_tdata = d;
        acc++;
      end
      check($sformatf("rot_tready_c%0d", c), {31'd0, s_tready}, {31'd0, c[0]});
      prev_ready = s_tready;
    end
    @(negedge aclk);
    if (prev_ready) acc++;
    s_tvalid = 1'b0;
    $display("rotation run accepted=%0d beats=%0d errs=%0d", acc, beat_count, err_count);
    check("rot_accepts", acc, 32'd4);
    check("rot_beats", beat_count, 32'd4);
    check("rot_errs", {16'd0, err_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
